// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified memory-port arbiter.
// The optional MEM_ARB_TIMEOUT_EN build uses TIMEOUT_CYC_DEF as its abort threshold.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 12;
    localparam int DATA_W_DEF      = 8;
    localparam int STARVE_LIM_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_XFER = 2'd1,
        EXT_XFER = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One req/ack memory port. The requester side uses the master modport and
// the responder side uses the slave modport.
interface mem_port_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    // Handshake: req is a level held until ack; we/addr/wdata stay stable while
    // req is high; ack is a single-cycle completion pulse and rdata is valid only with ack.
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive contested CPU grants; sat tells the
// arbiter that the external port must win the next contested decision.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIM = STARVE_LIM_DEF,
    parameter int W   = $clog2(LIM + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = (cnt == W'(LIM));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU datapath (fixed priority) and an external
// loader port, with a starvation limiter. Optional abort timer: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF,
`ifdef MEM_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
    parameter int SC_W       = $clog2(STARVE_LIM + 1)
) (
    input  logic            clk,
    input  logic            rst,
    mem_port_if.slave       cpu,
    mem_port_if.slave       ext,
    mem_port_if.master      mem,
    output logic            busy,
    output logic            err,
    output arb_state_e      state_dbg,
    output logic [SC_W-1:0] starve_cnt
);

    arb_state_e        state_q, state_d;
    owner_e            win;
    logic              grant;
    logic              done;
    logic              tmo;
    logic              sat;
    logic              sc_inc, sc_clr;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    arb_starve_counter #(.LIM(STARVE_LIM)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (sc_inc),
        .clr (sc_clr),
        .cnt (starve_cnt),
        .sat (sat)
    );

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr_q;

    // A real mem_ack in the threshold cycle wins over the abort.
    assign tmo = busy && !mem.ack && (tmr_q == TMR_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
        end else if (grant) begin
            tmr_q <= '0;
        end else if (busy && !mem.ack && !tmo) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign done = busy && (mem.ack || tmo);
    assign err  = tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win     = OWN_CPU;
        grant   = 1'b0;
        sc_inc  = 1'b0;
        sc_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // CPU wins contests until the limiter saturates, then ext gets one turn.
                if (ext.req && (!cpu.req || sat)) begin
                    win     = OWN_EXT;
                    grant   = 1'b1;
                    sc_clr  = 1'b1;
                    state_d = EXT_XFER;
                end else if (cpu.req) begin
                    win     = OWN_CPU;
                    grant   = 1'b1;
                    sc_inc  = ext.req;
                    sc_clr  = !ext.req;
                    state_d = CPU_XFER;
                end
            end
            CPU_XFER, EXT_XFER: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (grant) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= (win == OWN_EXT) ? ext.we    : cpu.we;
            mem_addr_q  <= (win == OWN_EXT) ? ext.addr  : cpu.addr;
            mem_wdata_q <= (win == OWN_EXT) ? ext.wdata : cpu.wdata;
        end else if (done) begin
            mem_req_q <= 1'b0;
        end
    end

    assign mem.req   = mem_req_q;
    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;

    // Acks are combinational from mem_ack so the owner sees completion in the same cycle.
    assign cpu.ack   = (state_q == CPU_XFER) && done;
    assign ext.ack   = (state_q == EXT_XFER) && done;
    assign cpu.rdata = (cpu.ack && mem.ack) ? mem.rdata : '0;
    assign ext.rdata = (ext.ack && mem.ack) ? mem.rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a behavioural memory
// responder, a reference memory and per-port expected-data queues.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int LIM  = 4;
  localparam int SCW  = $clog2(LIM + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            busy;
  logic            err;
  arb_state_e      state_dbg;
  logic [SCW-1:0]  starve_cnt;

  mem_port_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  mem_port_if #(.ADDR_W(AW), .DATA_W(DW)) ext_if ();
  mem_port_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .ext        (ext_if),
    .mem        (mem_if),
    .busy       (busy),
    .err        (err),
    .state_dbg  (state_dbg),
    .starve_cnt (starve_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_array [4096];
  logic [DW-1:0] ref_mem   [4096];
  logic [DW-1:0] cpu_exp_q [$];
  logic [DW-1:0] ext_exp_q [$];

  int mem_lat  = 1;
  bit lat_rand = 1'b0;
  bit mem_hang = 1'b0;
  bit spur_ack = 1'b0;
  bit resp_active = 1'b0;
  int lat_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // memory responder: ack arrives lat cycles after mem_req is first seen
  always begin
    @(posedge clk); #1;
    mem_if.ack   = 1'b0;
    mem_if.rdata = '0;
    if (spur_ack) begin
      mem_if.ack   = 1'b1;
      mem_if.rdata = 8'h55;
      spur_ack     = 1'b0;
    end else if (!mem_if.req) begin
      resp_active = 1'b0;
    end else if (!resp_active) begin
      resp_active = 1'b1;
      lat_left    = lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
    end else begin
      lat_left--;
      if (lat_left == 0 && !mem_hang) begin
        mem_if.ack = 1'b1;
        if (mem_if.we) mem_array[mem_if.addr] = mem_if.wdata;
        else           mem_if.rdata = mem_array[mem_if.addr];
        resp_active = 1'b0;
      end
    end
  end

  // ack exclusivity and idle-side rdata
  always @(negedge clk) begin
    if (cpu_if.ack || ext_if.ack) begin
      chk("one_ack", 32'(cpu_if.ack & ext_if.ack), 32'd0);
      if (cpu_if.ack) chk("ext_rdata_zero", 32'(ext_if.rdata), 32'd0);
      if (ext_if.ack) chk("cpu_rdata_zero", 32'(cpu_if.rdata), 32'd0);
    end
  end

  // driver tasks
  task automatic wait_mem_req();
    int n = 0;
    @(negedge clk);
    while (!mem_if.req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mem_req_seen", 32'(mem_if.req), 32'd1);
  endtask

  task automatic wait_ack_cyc(input bit who, output int cyc, output bit got);
    cyc = 0;
    got = who ? ext_if.ack : cpu_if.ack;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      got = who ? ext_if.ack : cpu_if.ack;
    end
  endtask

  task automatic do_xfer(input bit who, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    bit got = 1'b0;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] obs_d;
    @(posedge clk); #1;
    if (!we) begin
      if (who) ext_exp_q.push_back(ref_mem[addr]);
      else     cpu_exp_q.push_back(ref_mem[addr]);
    end
    if (who) begin
      ext_if.req = 1'b1; ext_if.we = we; ext_if.addr = addr; ext_if.wdata = wdata;
    end else begin
      cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
    end
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = who ? ext_if.ack : cpu_if.ack;
    end
    chk(who ? "ext_ack_seen" : "cpu_ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("xfer_err", 32'(err), 32'd0);
      chk("xfer_addr", 32'(mem_if.addr), 32'(addr));
      chk("xfer_we", 32'(mem_if.we), 32'(we));
      if (we) begin
        ref_mem[addr] = wdata;
      end else begin
        exp_d = who ? ext_exp_q.pop_front() : cpu_exp_q.pop_front();
        obs_d = who ? ext_if.rdata : cpu_if.rdata;
        chk(who ? "ext_rdata" : "cpu_rdata", 32'(obs_d), 32'(exp_d));
      end
    end
    @(posedge clk); #1;
    if (who) ext_if.req = 1'b0;
    else     cpu_if.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cyc;
    bit  got;
    bit  exp_ext;
    int  cnt_model;
    int  stray;
    logic [DW-1:0] v;

    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    ext_if.req = 1'b0; ext_if.we = 1'b0; ext_if.addr = '0; ext_if.wdata = '0;
    mem_if.ack = 1'b0; mem_if.rdata = '0;
    for (int i = 0; i < 4096; i++) begin
      v = 8'($urandom);
      mem_array[i] = v;
      ref_mem[i]   = v;
    end
    mem_array[12'h0A5] = 8'h3C;
    ref_mem[12'h0A5]   = 8'h3C;

    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_if.req), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_if.ack), 32'd0);
    chk("rst_ext_ack", 32'(ext_if.ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_starve", 32'(starve_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // CPU read, latency 3
    mem_lat = 3;
    @(posedge clk); #1;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 12'h0A5; cpu_if.wdata = 8'h00;
    @(negedge clk);
    chk("cpu_rd_req_wait", 32'(mem_if.req), 32'd0);
    @(negedge clk);
    chk("cpu_rd_mem_req", 32'(mem_if.req), 32'd1);
    chk("cpu_rd_addr", 32'(mem_if.addr), 32'h0A5);
    chk("cpu_rd_we", 32'(mem_if.we), 32'd0);
    chk("cpu_rd_state", 32'(state_dbg), 32'(CPU_XFER));
    wait_ack_cyc(1'b0, cyc, got);
    chk("cpu_rd_latency", 32'(cyc), 32'd3);
    chk("cpu_rd_rdata", 32'(cpu_if.rdata), 32'h3C);
    chk("cpu_rd_ext_ack", 32'(ext_if.ack), 32'd0);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    @(negedge clk);
    chk("cpu_rd_busy_fall", 32'(busy), 32'd0);
    chk("cpu_rd_req_fall", 32'(mem_if.req), 32'd0);
    chk("cpu_rd_ack_once", 32'(cpu_if.ack), 32'd0);

    // ext write, latency 2
    mem_lat = 2;
    @(posedge clk); #1;
    ext_if.req = 1'b1; ext_if.we = 1'b1; ext_if.addr = 12'h100; ext_if.wdata = 8'h7E;
    @(negedge clk);
    @(negedge clk);
    chk("ext_wr_we", 32'(mem_if.we), 32'd1);
    chk("ext_wr_addr", 32'(mem_if.addr), 32'h100);
    chk("ext_wr_wdata", 32'(mem_if.wdata), 32'h7E);
    chk("ext_wr_state", 32'(state_dbg), 32'(EXT_XFER));
    wait_ack_cyc(1'b1, cyc, got);
    chk("ext_wr_latency", 32'(cyc), 32'd2);
    chk("ext_wr_cpu_ack", 32'(cpu_if.ack), 32'd0);
    @(posedge clk); #1;
    ext_if.req = 1'b0;
    ref_mem[12'h100] = 8'h7E;
    @(negedge clk);
    chk("ext_wr_busy_fall", 32'(busy), 32'd0);
    chk("ext_wr_stored", 32'(mem_array[12'h100]), 32'h7E);

    // stray mem_ack while idle
    spur_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_cpu", 32'(cpu_if.ack), 32'd0);
    chk("idle_ack_ext", 32'(ext_if.ack), 32'd0);
    chk("idle_ack_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_ack_state", 32'(state_dbg), 32'(IDLE));
    chk("idle_ack_mem_req", 32'(mem_if.req), 32'd0);

    // both requesting continuously, latency 1
    mem_lat = 1;
    cnt_model = 0;
    @(posedge clk); #1;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 12'h011;
    ext_if.req = 1'b1; ext_if.we = 1'b0; ext_if.addr = 12'h822;
    for (int g = 0; g < 12; g++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(cpu_if.ack || ext_if.ack) && cyc < 40);
      exp_ext = ((g % (LIM + 1)) == LIM);
      chk("grant_any", 32'(cpu_if.ack | ext_if.ack), 32'd1);
      chk("grant_order", 32'(ext_if.ack), 32'(exp_ext));
      if (g > 0) chk("grant_spacing", 32'(cyc), 32'd3);
      if (exp_ext) cnt_model = 0;
      else         cnt_model = (cnt_model < LIM) ? cnt_model + 1 : LIM;
    end
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    ext_if.req = 1'b0;
    @(negedge clk);
    chk("contend_starve", 32'(starve_cnt), 32'(cnt_model));

    // uncontested CPU grant clears the limiter
    do_xfer(1'b0, 1'b0, 12'h033, 8'h00);
    @(negedge clk);
    chk("solo_cpu_starve", 32'(starve_cnt), 32'd0);

    // CPU request arriving during an ext transfer
    mem_lat = 4;
    @(posedge clk); #1;
    ext_if.req = 1'b1; ext_if.we = 1'b0; ext_if.addr = 12'h9AB;
    ext_exp_q.push_back(ref_mem[12'h9AB]);
    wait_mem_req();
    @(posedge clk); #1;
    cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 12'h0C0; cpu_if.wdata = 8'h5A;
    @(negedge clk);
    chk("wait_addr_hold", 32'(mem_if.addr), 32'h9AB);
    chk("wait_state", 32'(state_dbg), 32'(EXT_XFER));
    @(posedge clk); #1;
    cpu_if.addr = 12'h0C1;
    wait_ack_cyc(1'b1, cyc, got);
    chk("wait_ext_ack", 32'(got), 32'd1);
    chk("wait_ext_rdata", 32'(ext_if.rdata), 32'(ext_exp_q.pop_front()));
    chk("wait_cpu_ack", 32'(cpu_if.ack), 32'd0);
    @(posedge clk); #1;
    ext_if.req = 1'b0;
    @(negedge clk);
    chk("wait_gap_req", 32'(mem_if.req), 32'd0);
    chk("wait_gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("wait_cpu_mem_req", 32'(mem_if.req), 32'd1);
    chk("wait_cpu_addr", 32'(mem_if.addr), 32'h0C1);
    chk("wait_cpu_wdata", 32'(mem_if.wdata), 32'h5A);
    wait_ack_cyc(1'b0, cyc, got);
    chk("wait_cpu_done", 32'(got), 32'd1);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    ref_mem[12'h0C1] = 8'h5A;

    // reset in the middle of a contested CPU transfer
    mem_lat = 8;
    @(posedge clk); #1;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 12'h044;
    ext_if.req = 1'b1; ext_if.we = 1'b0; ext_if.addr = 12'h844;
    wait_mem_req();
    @(negedge clk);
    chk("pre_rst_state", 32'(state_dbg), 32'(CPU_XFER));
    chk("pre_rst_starve", 32'(starve_cnt), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_if.req), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_cpu_ack", 32'(cpu_if.ack), 32'd0);
    chk("async_rst_starve", 32'(starve_cnt), 32'd0);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    ext_if.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_if.ack || ext_if.ack || mem_if.req) stray++;
    end
    chk("post_rst_no_ack", 32'(stray), 32'd0);
    chk("post_rst_state", 32'(state_dbg), 32'(IDLE));

    // randomized concurrent traffic
    lat_rand = 1'b1;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_xfer(1'b0, 1'($urandom_range(0, 1)), {1'b0, 11'($urandom)}, 8'($urandom));
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_xfer(1'b1, 1'($urandom_range(0, 1)), {1'b1, 11'($urandom)}, 8'($urandom));
        end
      end
    join
    lat_rand = 1'b0;
    repeat (2) @(negedge clk);
    chk("rand_idle_busy", 32'(busy), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers: abort after the timeout
    mem_hang = 1'b1;
    @(posedge clk); #1;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 12'h0A5;
    wait_mem_req();
    wait_ack_cyc(1'b0, cyc, got);
    chk("tmo_cycles", 32'(cyc), 32'(TIMEOUT_CYC_DEF));
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_rdata", 32'(cpu_if.rdata), 32'd0);
    @(posedge clk); #1;
    cpu_if.req = 1'b0;
    mem_hang   = 1'b0;
    @(negedge clk);
    chk("tmo_req_fall", 32'(mem_if.req), 32'd0);
    chk("tmo_err_fall", 32'(err), 32'd0);
    spur_ack = 1'b1;
    @(negedge clk);
    chk("tmo_late_ack", 32'(cpu_if.ack), 32'd0);
    chk("tmo_late_busy", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the processor's single unified memory port between two requesters: the multicycle CPU datapath (instruction fetch and accumulator load/store) and an external loader/debug port (ext).
- CPU has fixed priority.
- A starvation limiter guarantees ext progress.
- Sits between the datapath's memory interface and the memory model.
- Req/ack handshake on all sides.

Parameters:
ADDR_W, 12, address width.
DATA_W, 8, data width.
STARVE_LIM, 4, consecutive contested CPU grants before ext is forced to win (>=1).
TIMEOUT_CYC, 16, cycles without mem_ack before abort (only with MEM_ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
cpu_req  in  1  CPU request, level, held until cpu_ack.
cpu_we  in  1  1=write, 0=read; stable while cpu_req.
cpu_addr  in  ADDR_W  CPU address.
cpu_wdata  in  DATA_W  CPU write data.
cpu_ack  out  1  one-cycle completion pulse.
cpu_rdata  out  DATA_W  read data, valid when cpu_ack.
ext_req / ext_we / ext_addr / ext_wdata  in  1/1/ADDR_W/DATA_W  same as CPU.
ext_ack  out  1  one-cycle completion pulse.
ext_rdata  out  DATA_W  read data, valid when ext_ack.
mem_req  out  1  memory request, registered.
mem_we  out  1  registered.
mem_addr  out  ADDR_W  registered.
mem_wdata  out  DATA_W  registered.
mem_rdata  in  DATA_W  valid with mem_ack.
mem_ack  in  1  one-cycle completion from memory, any latency >=1.
busy  out  1  transfer in progress (state != IDLE).
err  out  1  pulses with owner ack on timeout abort.

Behaviour:
- Reset (rst=0, async): state=IDLE, starve_cnt=0, all outputs 0.
- States:
  - IDLE:
    - Winner = ext if ext_req && (!cpu_req || starve_cnt==STARVE_LIM); else cpu if cpu_req; else stay.
    - On grant, latch winner's we/addr/wdata into mem_* and set mem_req=1 at the same edge (mem_req visible the cycle after the grant decision).
    - Next state CPU_XFER or EXT_XFER.
  - CPU_XFER / EXT_XFER:
    - Hold mem_* stable.
    - On mem_ack: mem_req=0 at the next edge; owner ack=1 combinationally in the mem_ack cycle; owner rdata=mem_rdata (other rdata=0); next state IDLE.
- Minimum one IDLE cycle between transfers. Back-to-back throughput is one transfer per (mem latency + 2) cycles.
- starve_cnt:
  - On CPU grant with ext_req=1: increment, saturating at STARVE_LIM.
  - On CPU grant with ext_req=0: cleared.
  - On ext grant: cleared.
- mem_ack in IDLE is ignored; no ack is routed.
- Requester dropping req mid-transfer: transfer completes, ack still pulses; requester must ignore it.
- Requests arriving during a transfer wait; evaluated in IDLE only.
- Reset mid-transfer: mem_req drops immediately; the pending transfer is lost with no ack.
- Non-owner ack is always 0; at most one ack is high per cycle.
- err=0 except under the optional feature.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - A cycle counter (width clog2(TIMEOUT_CYC+1)) clears on grant and counts each XFER cycle without mem_ack.
  - On reaching TIMEOUT_CYC: pulse owner ack and err for one cycle with owner rdata=0; mem_req=0 at the next edge; go to IDLE.
  - A late mem_ack arriving in IDLE is ignored.
- Undefined: no counter; XFER waits indefinitely; err tied 0.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, CPU_XFER, EXT_XFER), owner encoding (OWN_CPU=0, OWN_EXT=1), default widths.
- Sub-module arb_starve_counter: saturating counter with inc/clr/sat flag, parameter LIM. The FSM and muxing stay in the top module.

Test Plan:
- CPU read, memory latency 3, cpu_addr=0x0A5, mem_rdata=0x3C -> mem_req high 1 cycle after cpu_req; mem_addr=0x0A5, mem_we=0; cpu_ack 1 cycle with cpu_rdata=0x3C; ext_ack stays 0.
- ext write ext_addr=0x100, ext_wdata=0x7E, cpu_req=0 -> mem_we=1, mem_wdata=0x7E; ext_ack pulses on mem_ack; busy falls the next cycle.
- cpu_req and ext_req both held continuously, STARVE_LIM=4, latency 1 -> grant order CPU,CPU,CPU,CPU,EXT,CPU,...; no two acks in the same cycle.
- cpu_req asserted during an ext transfer -> CPU waits; granted in the IDLE cycle after ext_ack; its addr is latched only then.
- rst=0 asserted mid-CPU_XFER -> mem_req, busy and acks go 0 asynchronously; after release, state is IDLE and starve_cnt=0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, memory never acks -> after 16 XFER cycles: cpu_ack=1, err=1, cpu_rdata=0; mem_req low next cycle; a late mem_ack is ignored.
